pll_reconfig_seq: RTL and testbench

- Sequences run-time reprogramming of the system PLL through its Avalon-MM reconfiguration core. Used to change output clock frequencies on the fly, e.g. when a core switches video timing.
- On a request it latches a counter set and writes mode, N, M and each C counter. With the fractional option it also writes M-fraction.
- It then issues START and waits for the PLL to report stable lock, with a timeout.
- Sits in the sys clock domain between the core's clock-select logic and the PLL reconfig core.

---
 rtl/pll_reconfig_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq
// Reprograms the system PLL through its Avalon-MM reconfiguration core.
// On an accepted request the N, M and C counter words are captured, then
// written one at a time (mode, N, M, C[0..NUM_C-1], optionally M-fraction,
// then START), after which the block waits for a stable synchronised lock
// or gives up after a timeout.
// Optional feature macro: PLL_FRAC_EN adds the M-fraction (K) write at
// address 0x07 between the last C write and START.

module pll_reconfig_seq #(
    parameter int NUM_C        = 4,
    parameter int LOCK_STABLE  = 256,
    parameter int LOCK_TIMEOUT = 2000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [17:0]           cfg_n,
    input  logic [17:0]           cfg_m,
    input  logic [NUM_C*18-1:0]   cfg_c,
    input  logic [31:0]           cfg_k,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  pll_locked,
    output logic [5:0]            mgmt_address,
    output logic                  mgmt_write,
    output logic [31:0]           mgmt_writedata,
    input  logic                  mgmt_waitrequest
);

    localparam int STABLE_W  = (LOCK_STABLE  > 1) ? $clog2(LOCK_STABLE)  : 1;
    localparam int TIMEOUT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    // The counters stop one short of the parameter: reaching the last
    // value with the condition still true is the terminal event.
    localparam logic [STABLE_W-1:0]  STABLE_LAST  = STABLE_W'(LOCK_STABLE - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(LOCK_TIMEOUT - 1);
    localparam logic [4:0]           C_LAST       = 5'(NUM_C - 1);

    localparam logic [5:0] ADDR_MODE  = 6'h00;
    localparam logic [5:0] ADDR_START = 6'h02;
    localparam logic [5:0] ADDR_N     = 6'h03;
    localparam logic [5:0] ADDR_M     = 6'h04;
    localparam logic [5:0] ADDR_C     = 6'h05;
    localparam logic [5:0] ADDR_K     = 6'h07;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MODE,
        S_WR_N,
        S_WR_M,
        S_WR_C,
        S_WR_K,
        S_START,
        S_WAIT_LOCK
    } state_t;

    state_t                state;
    state_t                wr_next;
    logic [17:0]           n_reg;
    logic [17:0]           m_reg;
    logic [NUM_C*18-1:0]   c_reg;
    logic [4:0]            c_idx;
    logic [17:0]           c_cur;
    logic [5:0]            wr_addr;
    logic [31:0]           wr_data;
    logic                  locked_meta;
    logic                  locked_sync;
    logic [STABLE_W-1:0]   stable_cnt;
    logic [TIMEOUT_W-1:0]  timeout_cnt;

`ifdef PLL_FRAC_EN
    logic [31:0]           k_reg;
`else
    logic                  unused_cfg_k;
    assign unused_cfg_k = ^cfg_k;
`endif

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_meta <= 1'b0;
            locked_sync <= 1'b0;
        end else begin
            locked_meta <= pll_locked;
            locked_sync <= locked_meta;
        end
    end

    // Select the C counter word addressed by the current loop index.
    always_comb begin
        c_cur = '0;
        for (int i = 0; i < NUM_C; i++) begin
            if (c_idx == 5'(i)) begin
                c_cur = c_reg[i*18 +: 18];
            end
        end
    end

    // Address, data and successor state for whichever write the FSM is on.
    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        wr_next = S_IDLE;
        case (state)
            S_MODE: begin
                wr_addr = ADDR_MODE;
                wr_next = S_WR_N;
            end
            S_WR_N: begin
                wr_addr = ADDR_N;
                wr_data = {14'b0, n_reg};
                wr_next = S_WR_M;
            end
            S_WR_M: begin
                wr_addr = ADDR_M;
                wr_data = {14'b0, m_reg};
                wr_next = S_WR_C;
            end
            S_WR_C: begin
                wr_addr = ADDR_C;
                wr_data = {9'b0, c_idx, c_cur};
`ifdef PLL_FRAC_EN
                wr_next = (c_idx == C_LAST) ? S_WR_K : S_WR_C;
`else
                wr_next = (c_idx == C_LAST) ? S_START : S_WR_C;
`endif
            end
`ifdef PLL_FRAC_EN
            S_WR_K: begin
                wr_addr = ADDR_K;
                wr_data = k_reg;
                wr_next = S_START;
            end
`endif
            S_START: begin
                wr_addr = ADDR_START;
                wr_next = S_WAIT_LOCK;
            end
            default: begin
                wr_next = S_IDLE;
            end
        endcase
    end

    // Main sequencer: capture on request, run the write chain, then watch lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            mgmt_write     <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
            n_reg          <= '0;
            m_reg          <= '0;
            c_reg          <= '0;
            c_idx          <= '0;
            stable_cnt     <= '0;
            timeout_cnt    <= '0;
`ifdef PLL_FRAC_EN
            k_reg          <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        n_reg <= cfg_n;
                        m_reg <= cfg_m;
                        c_reg <= cfg_c;
`ifdef PLL_FRAC_EN
                        k_reg <= cfg_k;
`endif
                        c_idx <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_MODE;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_sync && (stable_cnt == STABLE_LAST)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        stable_cnt  <= locked_sync ? (stable_cnt + 1'b1) : '0;
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                default: begin
                    // Every write state: raise the strobe from a low cycle,
                    // hold it through waitrequest, drop it once accepted.
                    if (!mgmt_write) begin
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= wr_addr;
                        mgmt_writedata <= wr_data;
                    end else if (!mgmt_waitrequest) begin
                        mgmt_write <= 1'b0;
                        state      <= wr_next;
                        if (state == S_WR_C) begin
                            c_idx <= c_idx + 5'd1;
                        end
                        if (state == S_START) begin
                            stable_cnt  <= '0;
                            timeout_cnt <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb_pll_reconfig_seq
// Scoreboard bench for pll_reconfig_seq: stimulus pushes the expected
// Avalon writes and completion events, an independent monitor pops and
// compares them whenever the DUT completes a write or signals done/err.
// Honours PLL_FRAC_EN in the same way as the design.

module tb_pll_reconfig_seq;

    localparam int NUM_C        = 4;
    localparam int LOCK_STABLE  = 256;
    localparam int LOCK_TIMEOUT = 1000;

    logic                clk;
    logic                rst_n;
    logic                req;
    logic [17:0]         cfg_n;
    logic [17:0]         cfg_m;
    logic [NUM_C*18-1:0] cfg_c;
    logic [31:0]         cfg_k;
    logic                busy;
    logic                done;
    logic                err;
    logic                pll_locked;
    logic [5:0]          mgmt_address;
    logic                mgmt_write;
    logic [31:0]         mgmt_writedata;
    logic                mgmt_waitrequest;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int kind;
        int delay;
        bit from_rise;
    } ev_t;

    wr_t exp_wr[$];
    ev_t exp_ev[$];

    int checks      = 0;
    int errors      = 0;
    int ncyc        = 0;
    int start_cyc   = 0;
    int rise_cyc    = 0;
    int writes_seen = 0;
    int events_seen = 0;
    int starts_seen = 0;
    int stall_addr  = -1;
    int stall_n     = 0;
    int m_hold      = 0;

    pll_reconfig_seq #(
        .NUM_C(NUM_C),
        .LOCK_STABLE(LOCK_STABLE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .cfg_n(cfg_n),
        .cfg_m(cfg_m),
        .cfg_c(cfg_c),
        .cfg_k(cfg_k),
        .busy(busy),
        .done(done),
        .err(err),
        .pll_locked(pll_locked),
        .mgmt_address(mgmt_address),
        .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata),
        .mgmt_waitrequest(mgmt_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global guard so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_busy"}, 32'(busy), 32'd0);
        check_value({tag, "_done"}, 32'(done), 32'd0);
        check_value({tag, "_err"}, 32'(err), 32'd0);
        check_value({tag, "_write"}, 32'(mgmt_write), 32'd0);
        check_value({tag, "_addr"}, 32'(mgmt_address), 32'd0);
        check_value({tag, "_data"}, mgmt_writedata, 32'd0);
    endtask

    task automatic push_wr(input logic [5:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_wr.push_back(w);
    endtask

    task automatic push_ev(input int kind, input int delay, input bit from_rise);
        ev_t e;
        e.kind      = kind;
        e.delay     = delay;
        e.from_rise = from_rise;
        exp_ev.push_back(e);
    endtask

    // Expected write chain for one request, built from the words given.
    task automatic push_sequence(input logic [17:0] n, input logic [17:0] m,
                                 input logic [NUM_C*18-1:0] c, input logic [31:0] k);
        logic [NUM_C*18-1:0] cv;
        cv = c;
        push_wr(6'h00, 32'h0);
        push_wr(6'h03, {14'b0, n});
        push_wr(6'h04, {14'b0, m});
        for (int i = 0; i < NUM_C; i++) begin
            push_wr(6'h05, {9'b0, 5'(i), cv[i*18 +: 18]});
        end
`ifdef PLL_FRAC_EN
        push_wr(6'h07, k);
`else
        if (k == 32'hFFFF_FFFF) begin
            $display("[TB] note: all-ones K is ignored without the fractional option");
        end
`endif
        push_wr(6'h02, 32'h0);
    endtask

    task automatic pulse_req(input bit check_accept);
        @(posedge clk);
        #2;
        req = 1'b1;
        @(posedge clk);
        #2;
        req = 1'b0;
        if (check_accept) begin
            check_value("busy_after_req", 32'(busy), 32'd1);
            check_value("err_after_req", 32'(err), 32'd0);
        end
    endtask

    // sel: 0 = completion events, 1 = accepted writes, 2 = START writes.
    task automatic wait_count(input int sel, input int target, input int budget, input string name);
        int n;
        int cur;
        n = 0;
        cur = (sel == 0) ? events_seen : ((sel == 1) ? writes_seen : starts_seen);
        while (cur < target && n < budget) begin
            @(posedge clk);
            n++;
            cur = (sel == 0) ? events_seen : ((sel == 1) ? writes_seen : starts_seen);
        end
        if (cur < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: count %0d after %0d cycles, required %0d", name, cur, budget, target);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #2;
    endtask

    // Reconfig-core model: optional stall on one address, stability check while stalled.
    initial begin : slave
        logic        in_xfer;
        logic [5:0]  hold_addr;
        logic [31:0] hold_data;
        int          stall_left;
        in_xfer          = 1'b0;
        hold_addr        = '0;
        hold_data        = '0;
        stall_left       = 0;
        mgmt_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !mgmt_write) begin
                in_xfer          = 1'b0;
                mgmt_waitrequest = 1'b0;
            end else begin
                if (!in_xfer) begin
                    in_xfer    = 1'b1;
                    hold_addr  = mgmt_address;
                    hold_data  = mgmt_writedata;
                    stall_left = (int'(mgmt_address) == stall_addr) ? stall_n : 0;
                end else begin
                    check_value("stall_addr_stable", 32'(mgmt_address), 32'(hold_addr));
                    check_value("stall_data_stable", mgmt_writedata, hold_data);
                end
                if (stall_left > 0) begin
                    mgmt_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    mgmt_waitrequest = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expected writes and events and compares them.
    initial begin : monitor
        logic prev_err;
        wr_t  w;
        ev_t  e;
        int   kind;
        int   ref_cyc;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (mgmt_write && mgmt_address == 6'h04) begin
                m_hold++;
            end
            if (rst_n && mgmt_write && !mgmt_waitrequest) begin
                writes_seen++;
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr %0h data %0h, required no write",
                             mgmt_address, mgmt_writedata);
                end else begin
                    w = exp_wr.pop_front();
                    if (mgmt_address !== w.addr || mgmt_writedata !== w.data) begin
                        errors++;
                        $display("[TB] FAIL write_%0d: got addr %0h data %0h, required addr %0h data %0h",
                                 writes_seen, mgmt_address, mgmt_writedata, w.addr, w.data);
                    end
                end
                if (mgmt_address == 6'h02) begin
                    start_cyc = ncyc;
                    starts_seen++;
                end
            end
            if (done || (err && !prev_err)) begin
                events_seen++;
                kind = done ? 1 : 2;
                checks++;
                if (exp_ev.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_event: got kind %0d, required none", kind);
                end else begin
                    e = exp_ev.pop_front();
                    if (kind != e.kind) begin
                        errors++;
                        $display("[TB] FAIL event_kind: got %0d, required %0d", kind, e.kind);
                    end
                    check_value("busy_at_event", 32'(busy), 32'd0);
                    if (e.delay >= 0) begin
                        ref_cyc = e.from_rise ? rise_cyc : start_cyc;
                        check_value("event_latency", 32'(ncyc - ref_cyc), 32'(e.delay));
                    end
                end
            end
            prev_err = err;
        end
    end

    initial begin : stimulus
        logic [NUM_C*18-1:0] c_a;
        logic [NUM_C*18-1:0] c_b;
        int base;

        rst_n      = 1'b0;
        req        = 1'b0;
        cfg_n      = '0;
        cfg_m      = '0;
        cfg_c      = '0;
        cfg_k      = '0;
        pll_locked = 1'b0;

        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle_cycles(2);
        check_reset_outputs("post_reset");

        // Test 1: zero-wait slave, hand-computed write table, lock already stable.
        $display("[TB] test 1: basic sequence");
        pll_locked = 1'b1;
        idle_cycles(4);
        cfg_n = 18'h00505;
        cfg_m = 18'h00C0C;
        cfg_c = {18'h00606, 18'h00505, 18'h00404, 18'h00303};
        cfg_k = 32'h1234_5678;
        push_wr(6'h00, 32'h0000_0000);
        push_wr(6'h03, 32'h0000_0505);
        push_wr(6'h04, 32'h0000_0C0C);
        push_wr(6'h05, 32'h0000_0303);
        push_wr(6'h05, 32'h0004_0404);
        push_wr(6'h05, 32'h0008_0505);
        push_wr(6'h05, 32'h000C_0606);
`ifdef PLL_FRAC_EN
        push_wr(6'h07, 32'h1234_5678);
`endif
        push_wr(6'h02, 32'h0000_0000);
        push_ev(1, LOCK_STABLE + 1, 1'b0);
        pulse_req(1'b1);
        wait_count(0, 1, 2000, "t1_done");
        check_value("t1_err", 32'(err), 32'd0);

        // Test 2: three waitrequest cycles on the M write.
        $display("[TB] test 2: stalled M write");
        stall_addr = 4;
        stall_n    = 3;
        m_hold     = 0;
        c_a   = {18'h20011, 18'h10022, 18'h3A5A5, 18'h00101};
        cfg_n = 18'h2A0F1;
        cfg_m = 18'h1C3E7;
        cfg_c = c_a;
        cfg_k = 32'hCAFE_0001;
        push_sequence(cfg_n, cfg_m, cfg_c, cfg_k);
        push_ev(1, LOCK_STABLE + 1, 1'b0);
        pulse_req(1'b1);
        wait_count(0, 2, 2000, "t2_done");
        check_value("t2_m_hold_cycles", 32'(m_hold), 32'd4);
        stall_addr = -1;
        stall_n    = 0;

        // Test 3: lock toggles every 100 cycles before holding high.
        $display("[TB] test 3: lock glitches");
        pll_locked = 1'b0;
        idle_cycles(4);
        cfg_n = 18'h00101;
        cfg_m = 18'h00202;
        cfg_c = {18'h00707, 18'h00808, 18'h00909, 18'h00A0A};
        push_sequence(cfg_n, cfg_m, cfg_c, cfg_k);
        push_ev(1, LOCK_STABLE + 2, 1'b1);
        base = starts_seen;
        pulse_req(1'b1);
        wait_count(2, base + 1, 500, "t3_start");
        for (int ph = 0; ph < 4; ph++) begin
            @(posedge clk);
            #2;
            pll_locked = (ph % 2 == 0) ? 1'b1 : 1'b0;
            idle_cycles(99);
        end
        @(posedge clk);
        #2;
        pll_locked = 1'b1;
        rise_cyc   = ncyc + 1;
        wait_count(0, 3, 1000, "t3_done");

        // Test 4: lock never arrives, timeout; next request clears err.
        $display("[TB] test 4: lock timeout");
        pll_locked = 1'b0;
        idle_cycles(4);
        push_sequence(cfg_n, cfg_m, cfg_c, cfg_k);
        push_ev(2, LOCK_TIMEOUT + 1, 1'b0);
        pulse_req(1'b1);
        wait_count(0, 4, 2000, "t4_err");
        #2;
        check_value("t4_err_set", 32'(err), 32'd1);
        check_value("t4_busy_clear", 32'(busy), 32'd0);
        idle_cycles(3);
        check_value("t4_err_sticky", 32'(err), 32'd1);
        pll_locked = 1'b1;
        idle_cycles(4);
        push_sequence(cfg_n, cfg_m, cfg_c, cfg_k);
        push_ev(1, LOCK_STABLE + 1, 1'b0);
        pulse_req(1'b1);
        wait_count(0, 5, 2000, "t4_retry_done");

        // Test 5: second request while busy is ignored; START stalled by core.
        $display("[TB] test 5: request while busy");
        stall_addr = 2;
        stall_n    = 20;
        c_b   = {18'h0F0F0, 18'h00E0E, 18'h00D0D, 18'h00C0C};
        cfg_n = 18'h01111;
        cfg_m = 18'h02222;
        cfg_c = c_b;
        cfg_k = 32'h0BAD_F00D;
        push_sequence(cfg_n, cfg_m, cfg_c, cfg_k);
        push_ev(1, LOCK_STABLE + 1, 1'b0);
        base = writes_seen;
        pulse_req(1'b1);
        wait_count(1, base + 5, 200, "t5_mid_c");
        cfg_n = 18'h3FFFF;
        cfg_m = 18'h3FFFF;
        cfg_c = '1;
        cfg_k = 32'hFFFF_FFFF;
        pulse_req(1'b0);
        wait_count(0, 6, 2000, "t5_done");
        idle_cycles(50);
`ifdef PLL_FRAC_EN
        check_value("t5_write_count", 32'(writes_seen - base), 32'(NUM_C + 5));
`else
        check_value("t5_write_count", 32'(writes_seen - base), 32'(NUM_C + 4));
`endif
        check_value("t5_busy_idle", 32'(busy), 32'd0);
        stall_addr = -1;
        stall_n    = 0;

        // Test 6: reset in the middle of the C writes, then a clean run.
        $display("[TB] test 6: reset mid-sequence");
        cfg_n = 18'h00ABC;
        cfg_m = 18'h00DEF;
        cfg_c = c_a;
        cfg_k = 32'h0000_F00D;
        push_sequence(cfg_n, cfg_m, cfg_c, cfg_k);
        base = writes_seen;
        pulse_req(1'b1);
        wait_count(1, base + 5, 200, "t6_mid_c");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async_reset");
        exp_wr.delete();
        idle_cycles(2);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle_cycles(3);
        check_reset_outputs("t6_after_release");
        push_sequence(cfg_n, cfg_m, cfg_c, cfg_k);
        push_ev(1, LOCK_STABLE + 1, 1'b0);
        pulse_req(1'b1);
        wait_count(0, 7, 2000, "t6_done");

        idle_cycles(10);
        check_value("exp_writes_left", 32'(exp_wr.size()), 32'd0);
        check_value("exp_events_left", 32'(exp_ev.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
